// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage operand issue block: MIPS opcode/func codes,
// ALU flag bit positions and the destination-register decode.
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LW    = 6'b100011;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SRAV = 6'b000111;

    localparam int FLG_OVF  = 0;
    localparam int FLG_NEG  = 1;
    localparam int FLG_ZERO = 2;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] func;
    } instr_t;

    // Stores, branches, jumps and unknown encodings write nothing (tag 0).
    function automatic logic [4:0] dest_decode(input instr_t i);
        logic [4:0] d;
        d = '0;
        case (i.op)
            OP_RTYPE: begin
                case (i.func)
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                    F_SLT, F_SLTU, F_SLL, F_SLLV, F_SRL, F_SRLV, F_SRA, F_SRAV: d = i.rd;
                    default: d = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LW: d = i.rt;
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_operand_issue_if.sv
// Bundle of the instruction-in, ID/EX-out, writeback and overflow-exception signals.
// slave is the issue block, master is whatever drives it.
interface alu_operand_issue_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [DATA_W-1:0] out_reg_a;
    logic [DATA_W-1:0] out_reg_b;
    logic [REG_AW-1:0] out_dest;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_result;
    logic [2:0]        wb_flags;
    logic              ovf_exc;
    logic [REG_AW-1:0] ovf_rd;

    modport slave (
        input  in_valid, in_instr, out_ready, wb_valid, wb_rd, wb_result, wb_flags,
        output in_ready, out_valid, out_instr, out_reg_a, out_reg_b, out_dest, ovf_exc, ovf_rd
    );

    modport master (
        output in_valid, in_instr, out_ready, wb_valid, wb_rd, wb_result, wb_flags,
        input  in_ready, out_valid, out_instr, out_reg_a, out_reg_b, out_dest, ovf_exc, ovf_rd
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Register file with two asynchronous read ports and one synchronous write port.
// r0 reads as zero; a same-cycle write is bypassed onto matching reads.
module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);
    localparam int NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];

    function automatic logic [DATA_W-1:0] read_port(input logic [REG_AW-1:0] addr);
        if (addr == '0)                    return '0;
        else if (we && waddr == addr)      return wdata;
        else                               return mem_q[addr];
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mem_d = mem_q;
        if (we && waddr != '0) mem_d[waddr] = wdata;
    end

    assign rdata_a = read_port(raddr_a);
    assign rdata_b = read_port(raddr_b);

    // NOTE: the array is built from flops, not a RAM macro, so it can be cleared by the async reset.
    // NOTE: sequential state uses <= so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/alu_operand_issue.sv
// EX-stage front end: reads operands with writeback forwarding, tracks pending writes
// to stall RAW/WAW hazards, and registers the issued instruction into the ID/EX register.
module alu_operand_issue
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input logic               clk,
    input logic               rst_n,
    alu_operand_issue_if.slave bus
);
    localparam int NREG = 2 ** REG_AW;
    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

    instr_t            in_i;
    logic [REG_AW-1:0] rs, rt, dest;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              wb_ovf, wb_we;
    logic [NREG-1:0]   clr_mask, set_mask, pend_eff;
    logic              hazard, in_ready, accept;

    logic [NREG-1:0]   pending_q, pending_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [DATA_W-1:0] out_reg_a_q, out_reg_a_d;
    logic [DATA_W-1:0] out_reg_b_q, out_reg_b_d;
    logic [REG_AW-1:0] out_dest_q, out_dest_d;
    logic              ovf_exc_q, ovf_exc_d;
    logic [REG_AW-1:0] ovf_rd_q, ovf_rd_d;

    assign in_i   = instr_t'(bus.in_instr);
    assign rs     = in_i.rs;
    assign rt     = in_i.rt;
    assign dest   = dest_decode(in_i);
    assign wb_ovf = bus.wb_flags[FLG_OVF];
    // An overflowed result never reaches the file, so it is not forwarded either.
    assign wb_we  = bus.wb_valid && !wb_ovf && (bus.wb_rd != '0);

    regfile_2r1w #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_we),
        .waddr   (bus.wb_rd),
        .wdata   (bus.wb_result),
        .raddr_a (rs),
        .rdata_a (rs_val),
        .raddr_b (rt),
        .rdata_b (rt_val)
    );

    always_comb begin
        clr_mask = bus.wb_valid ? (ONE << bus.wb_rd) : '0;
        pend_eff = pending_q & ~clr_mask;
        hazard   = pend_eff[rs] || pend_eff[rt] || ((dest != '0) && pend_eff[dest]);
        in_ready = (!out_valid_q || bus.out_ready) && !hazard;
        accept   = bus.in_valid && in_ready;
        set_mask = (accept && dest != '0) ? (ONE << dest) : '0;
        pending_d = ((pending_q & ~clr_mask) | set_mask) & ~ONE;

        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_reg_a_d = out_reg_a_q;
        out_reg_b_d = out_reg_b_q;
        out_dest_d  = out_dest_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = bus.in_instr;
            out_reg_a_d = rs_val;
            out_reg_b_d = rt_val;
            out_dest_d  = dest;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        ovf_exc_d = bus.wb_valid && wb_ovf;
        ovf_rd_d  = ovf_exc_d ? bus.wb_rd : ovf_rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_reg_a_q <= '0;
            out_reg_b_q <= '0;
            out_dest_q  <= '0;
            ovf_exc_q   <= 1'b0;
            ovf_rd_q    <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_reg_a_q <= out_reg_a_d;
            out_reg_b_q <= out_reg_b_d;
            out_dest_q  <= out_dest_d;
            ovf_exc_q   <= ovf_exc_d;
            ovf_rd_q    <= ovf_rd_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_reg_a = out_reg_a_q;
    assign bus.out_reg_b = out_reg_b_q;
    assign bus.out_dest  = out_dest_q;
    assign bus.ovf_exc   = ovf_exc_q;
    assign bus.ovf_rd    = ovf_rd_q;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Self-checking bench for alu_operand_issue: directed scenarios plus random traffic,
// all compared against an array-based reference model of the issue rules.
module tb_alu_operand_issue;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_operand_issue_if #(.DATA_W(32), .REG_AW(5)) bus ();

    alu_operand_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit [31:0] m_reg [32];
    bit        m_pend [32];
    bit        m_ov;
    bit [31:0] m_oi, m_oa, m_ob;
    bit [4:0]  m_od;
    bit        m_exc;
    bit [4:0]  m_exc_rd;
    logic      seen_ready;

    localparam bit [5:0] RFN [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                      6'h2a, 6'h2b, 6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07};
    localparam bit [5:0] IOP [8]  = '{6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0b, 6'h23};

    function automatic bit [31:0] enc_r(bit [5:0] fn, bit [4:0] rd, bit [4:0] rs, bit [4:0] rt);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic bit [31:0] enc_i(bit [5:0] op, bit [4:0] rt, bit [4:0] rs, bit [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic int ref_dest(bit [31:0] ins);
        bit [5:0] op;
        bit [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'd0) begin
            for (int k = 0; k < 16; k++) if (RFN[k] == fn) return int'(ins[15:11]);
            return 0;
        end
        for (int k = 0; k < 8; k++) if (IOP[k] == op) return int'(ins[20:16]);
        return 0;
    endfunction

    function automatic bit [31:0] ref_read(int r, bit wv, int wrd, bit [31:0] wres, bit ovf);
        if (r == 0) return 32'd0;
        if (wv && !ovf && wrd == r) return wres;
        return m_reg[r];
    endfunction

    function automatic bit ref_ready(bit [31:0] ins, bit ordy, bit wv, int wrd);
        bit pe [32];
        int rs, rt, d;
        for (int k = 0; k < 32; k++) pe[k] = m_pend[k];
        if (wv) pe[wrd] = 1'b0;
        rs = int'(ins[25:21]);
        rt = int'(ins[20:16]);
        d  = ref_dest(ins);
        if (pe[rs] || pe[rt] || (d != 0 && pe[d])) return 1'b0;
        return !m_ov || ordy;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            m_reg[k]  = '0;
            m_pend[k] = 1'b0;
        end
        m_ov = 0; m_oi = 0; m_oa = 0; m_ob = 0; m_od = 0; m_exc = 0; m_exc_rd = 0;
    endtask

    // Entered and left at a falling edge: drive, check in_ready, clock, check registered outputs.
    task automatic cycle(input bit iv, input bit [31:0] ins, input bit ordy, input bit wv,
                         input bit [4:0] wrd, input bit [31:0] wres, input bit [2:0] wfl);
        bit exp_rdy, acc;
        int d;
        bus.in_valid  = iv;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
        bus.wb_valid  = wv;
        bus.wb_rd     = wrd;
        bus.wb_result = wres;
        bus.wb_flags  = wfl;
        #1;
        exp_rdy = ref_ready(ins, ordy, wv, int'(wrd));
        seen_ready = bus.in_ready;
        n_vec++;
        if (bus.in_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL in_ready: got %b expected %b (instr %h)", bus.in_ready, exp_rdy, ins);
        end
        @(posedge clk);
        acc = iv && exp_rdy;
        d = ref_dest(ins);
        if (acc) begin
            m_oi = ins;
            m_oa = ref_read(int'(ins[25:21]), wv, int'(wrd), wres, wfl[0]);
            m_ob = ref_read(int'(ins[20:16]), wv, int'(wrd), wres, wfl[0]);
            m_od = d[4:0];
            m_ov = 1'b1;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        m_exc = wv && wfl[0];
        if (m_exc) m_exc_rd = wrd;
        if (wv && !wfl[0] && wrd != 0) m_reg[wrd] = wres;
        if (wv) m_pend[wrd] = 1'b0;
        if (acc && d != 0) m_pend[d] = 1'b1;
        @(negedge clk);
        n_vec += 6;
        if (bus.out_valid !== m_ov) begin
            n_err++; $display("FAIL out_valid: got %b expected %b", bus.out_valid, m_ov);
        end
        if (bus.out_instr !== m_oi) begin
            n_err++; $display("FAIL out_instr: got %h expected %h", bus.out_instr, m_oi);
        end
        if (bus.out_reg_a !== m_oa) begin
            n_err++; $display("FAIL out_reg_a: got %h expected %h", bus.out_reg_a, m_oa);
        end
        if (bus.out_reg_b !== m_ob) begin
            n_err++; $display("FAIL out_reg_b: got %h expected %h", bus.out_reg_b, m_ob);
        end
        if (bus.out_dest !== m_od) begin
            n_err++; $display("FAIL out_dest: got %0d expected %0d", bus.out_dest, m_od);
        end
        if (bus.ovf_exc !== m_exc) begin
            n_err++; $display("FAIL ovf_exc: got %b expected %b", bus.ovf_exc, m_exc);
        end
        if (m_exc) begin
            n_vec++;
            if (bus.ovf_rd !== m_exc_rd) begin
                n_err++; $display("FAIL ovf_rd: got %0d expected %0d", bus.ovf_rd, m_exc_rd);
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 3'b000);
    endtask

    task automatic wb(input bit [4:0] rd, input bit [31:0] res, input bit [2:0] fl);
        cycle(1'b0, 32'd0, 1'b1, 1'b1, rd, res, fl);
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.in_instr = 0; bus.out_ready = 1;
        bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_result = 0; bus.wb_flags = 0;
        model_reset();
        @(negedge clk);
        n_vec += 4;
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid); end
        if (bus.out_instr !== 32'd0) begin n_err++; $display("FAIL reset out_instr: got %h expected 0", bus.out_instr); end
        if (bus.out_dest !== 5'd0) begin n_err++; $display("FAIL reset out_dest: got %0d expected 0", bus.out_dest); end
        if (bus.ovf_exc !== 1'b0) begin n_err++; $display("FAIL reset ovf_exc: got %b expected 0", bus.ovf_exc); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_issue();
        wb(5'd1, 32'd5, 3'b000);
        wb(5'd2, 32'd7, 3'b000);
        cycle(1'b1, enc_r(6'h21, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 5'd0, 32'd0, 3'b000);
        n_vec += 3;
        if (bus.out_reg_a !== 32'd5) begin n_err++; $display("FAIL basic reg_a: got %0d expected 5", bus.out_reg_a); end
        if (bus.out_reg_b !== 32'd7) begin n_err++; $display("FAIL basic reg_b: got %0d expected 7", bus.out_reg_b); end
        if (bus.out_dest !== 5'd3) begin n_err++; $display("FAIL basic dest: got %0d expected 3", bus.out_dest); end
    endtask

    task automatic test_raw_stall();
        bit [31:0] rd4;
        rd4 = enc_r(6'h21, 5'd4, 5'd3, 5'd3);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, rd4, 1'b1, 1'b0, 5'd0, 32'd0, 3'b000);
            n_vec++;
            if (seen_ready !== 1'b0) begin n_err++; $display("FAIL raw stall: got in_ready %b expected 0", seen_ready); end
        end
        cycle(1'b1, rd4, 1'b1, 1'b1, 5'd3, 32'd12, 3'b000);
        n_vec += 3;
        if (seen_ready !== 1'b1) begin n_err++; $display("FAIL raw release: got in_ready %b expected 1", seen_ready); end
        if (bus.out_reg_a !== 32'd12) begin n_err++; $display("FAIL raw fwd a: got %0d expected 12", bus.out_reg_a); end
        if (bus.out_reg_b !== 32'd12) begin n_err++; $display("FAIL raw fwd b: got %0d expected 12", bus.out_reg_b); end
        wb(5'd4, 32'd24, 3'b000);
        cycle(1'b1, enc_r(6'h21, 5'd13, 5'd3, 5'd0), 1'b1, 1'b0, 5'd0, 32'd0, 3'b000);
        n_vec++;
        if (bus.out_reg_a !== 32'd12) begin n_err++; $display("FAIL reg3 stored: got %0d expected 12", bus.out_reg_a); end
        wb(5'd13, 32'd12, 3'b000);
    endtask

    task automatic test_waw();
        bit [31:0] w2, rdr;
        w2  = enc_r(6'h21, 5'd5, 5'd1, 5'd2);
        rdr = enc_r(6'h21, 5'd7, 5'd5, 5'd0);
        cycle(1'b1, enc_i(6'h09, 5'd5, 5'd0, 16'd1), 1'b1, 1'b0, 5'd0, 32'd0, 3'b000);
        cycle(1'b1, w2, 1'b1, 1'b0, 5'd0, 32'd0, 3'b000);
        n_vec++;
        if (seen_ready !== 1'b0) begin n_err++; $display("FAIL waw stall: got in_ready %b expected 0", seen_ready); end
        cycle(1'b1, w2, 1'b1, 1'b1, 5'd5, 32'd1, 3'b000);
        n_vec++;
        if (seen_ready !== 1'b1) begin n_err++; $display("FAIL waw release: got in_ready %b expected 1", seen_ready); end
        cycle(1'b1, rdr, 1'b1, 1'b0, 5'd0, 32'd0, 3'b000);
        n_vec++;
        if (seen_ready !== 1'b0) begin n_err++; $display("FAIL waw still pending: got in_ready %b expected 0", seen_ready); end
        cycle(1'b1, rdr, 1'b1, 1'b1, 5'd5, 32'd12, 3'b000);
        n_vec++;
        if (bus.out_reg_a !== 32'd12) begin n_err++; $display("FAIL waw fwd: got %0d expected 12", bus.out_reg_a); end
        wb(5'd7, 32'd12, 3'b000);
    endtask

    task automatic test_overflow();
        bit [31:0] rdr;
        rdr = enc_r(6'h21, 5'd8, 5'd6, 5'd1);
        cycle(1'b1, enc_r(6'h20, 5'd6, 5'd1, 5'd2), 1'b1, 1'b0, 5'd0, 32'd0, 3'b000);
        cycle(1'b1, rdr, 1'b1, 1'b0, 5'd0, 32'd0, 3'b000);
        n_vec++;
        if (seen_ready !== 1'b0) begin n_err++; $display("FAIL ovf reader stall: got in_ready %b expected 0", seen_ready); end
        cycle(1'b1, rdr, 1'b1, 1'b1, 5'd6, 32'h8000_0000, 3'b001);
        n_vec += 4;
        if (bus.ovf_exc !== 1'b1) begin n_err++; $display("FAIL ovf pulse: got %b expected 1", bus.ovf_exc); end
        if (bus.ovf_rd !== 5'd6) begin n_err++; $display("FAIL ovf tag: got %0d expected 6", bus.ovf_rd); end
        if (bus.out_reg_a !== 32'd0) begin n_err++; $display("FAIL ovf old value: got %h expected 0", bus.out_reg_a); end
        if (bus.out_reg_b !== 32'd5) begin n_err++; $display("FAIL ovf reader b: got %0d expected 5", bus.out_reg_b); end
        wb(5'd8, 32'd5, 3'b000);
        n_vec++;
        if (bus.ovf_exc !== 1'b0) begin n_err++; $display("FAIL ovf one-shot: got %b expected 0", bus.ovf_exc); end
    endtask

    task automatic test_backpressure();
        bit [31:0] i1, i2;
        i1 = enc_r(6'h21, 5'd9, 5'd1, 5'd2);
        i2 = enc_r(6'h23, 5'd10, 5'd2, 5'd1);
        cycle(1'b1, i1, 1'b1, 1'b0, 5'd0, 32'd0, 3'b000);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, i2, 1'b0, 1'b0, 5'd0, 32'd0, 3'b000);
            n_vec += 3;
            if (seen_ready !== 1'b0) begin n_err++; $display("FAIL bp ready: got %b expected 0", seen_ready); end
            if (bus.out_instr !== i1) begin n_err++; $display("FAIL bp hold instr: got %h expected %h", bus.out_instr, i1); end
            if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp hold valid: got %b expected 1", bus.out_valid); end
        end
        cycle(1'b1, i2, 1'b1, 1'b0, 5'd0, 32'd0, 3'b000);
        n_vec += 3;
        if (seen_ready !== 1'b1) begin n_err++; $display("FAIL bp release: got %b expected 1", seen_ready); end
        if (bus.out_instr !== i2) begin n_err++; $display("FAIL bp no bubble: got %h expected %h", bus.out_instr, i2); end
        if (bus.out_reg_a !== 32'd7) begin n_err++; $display("FAIL bp reg_a: got %0d expected 7", bus.out_reg_a); end
        wb(5'd9, 32'd12, 3'b000);
        wb(5'd10, 32'd2, 3'b000);
    endtask

    task automatic test_async_reset();
        wb(5'd3, 32'd77, 3'b000);
        cycle(1'b1, enc_r(6'h21, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 5'd0, 32'd0, 3'b000);
        bus.in_valid = 1'b1;
        bus.in_instr = enc_r(6'h21, 5'd11, 5'd3, 5'd0);
        bus.wb_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec += 3;
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL async out_valid: got %b expected 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL async pending clear: got in_ready %b expected 1", bus.in_ready); end
        if (bus.out_dest !== 5'd0) begin n_err++; $display("FAIL async out_dest: got %0d expected 0", bus.out_dest); end
        bus.in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, enc_r(6'h21, 5'd12, 5'd3, 5'd0), 1'b1, 1'b0, 5'd0, 32'd0, 3'b000);
        n_vec++;
        if (bus.out_reg_a !== 32'd0) begin n_err++; $display("FAIL async r3 cleared: got %0d expected 0", bus.out_reg_a); end
        wb(5'd12, 32'd0, 3'b000);
    endtask

    task automatic test_random();
        bit [31:0] ins;
        bit [4:0]  a, b, c;
        for (int n = 0; n < 400; n++) begin
            a = 5'($urandom_range(0, 7));
            b = 5'($urandom_range(0, 7));
            c = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: ins = enc_r(RFN[$urandom_range(0, 15)], a, b, c);
                1: ins = enc_i(IOP[$urandom_range(0, 7)], a, b, 16'($urandom));
                2: ins = enc_i(6'h2b, a, b, 16'($urandom));
                default: ins = enc_r(6'h08, a, b, c);
            endcase
            cycle(1'($urandom_range(0, 1)), ins, ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  {2'($urandom), ($urandom_range(0, 7) == 0)});
        end
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_raw_stall();
        test_waw();
        test_overflow();
        test_backpressure();
        test_async_reset();
        test_random();
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
